// File: rtl/dsdac_pkg.sv
// Shared definitions for the delta-sigma DAC: controller states and default sample width.
package dsdac_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/dsdac_mod.sv
// First-order delta-sigma modulator: accumulate the level on each tick, emit the carry as the bit.
module dsdac_mod
    import dsdac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_level,
    output logic             o_pdm
);

    logic [WIDTH-1:0] r_acc;
    logic             r_pdm;
    logic [WIDTH:0]   w_sum;

    // Accumulator overflow is the output bit, so the wrap of r_acc is intended.
    assign w_sum = {1'b0, r_acc} + {1'b0, i_level};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else if (i_tick) begin
            r_acc <= w_sum[WIDTH-1:0];
            r_pdm <= w_sum[WIDTH];
        end
    end

    assign o_pdm = r_pdm;

endmodule

// File: rtl/dsdac.sv
// Delta-sigma DAC top: tick/frame timing, one-entry sample buffer, soft-start ramp and run control.
module dsdac
    import dsdac_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int RAMP_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       divider,
    input  logic [9:0]       osr,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pdmout,
    output logic             underrun,
    output logic             running
);

    localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(RAMP_STEP);

    state_t           r_state;
    state_t           w_state_next;
    logic [4:0]       r_divctr;
    logic [9:0]       r_framectr;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic             r_underrun;

    logic             w_tick;
    logic             w_boundary;
    logic             w_accept;
    logic             w_load;
    logic             w_starve;
    logic [WIDTH:0]   w_ramp_sum;
    logic [WIDTH-1:0] w_ramp_next;

    assign w_tick     = (r_divctr >= divider);
    // Compared with >= so a live shrink of osr cannot strand the counter above it.
    assign w_boundary = w_tick && (r_framectr >= osr);
    assign w_accept   = sample_valid && sample_ready;
    assign w_load     = (r_state == RUN) && w_boundary && r_buf_full;
    assign w_starve   = (r_state == RUN) && w_boundary && !r_buf_full;

    assign w_ramp_sum  = {1'b0, r_active} + STEP_EXT;
    assign w_ramp_next = (w_ramp_sum >= {1'b0, HALF}) ? HALF : w_ramp_sum[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = RAMP;
            RAMP:    if (r_active >= HALF) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_divctr   <= '0;
            r_framectr <= '0;
        end else begin
            r_divctr <= w_tick ? 5'd0 : r_divctr + 5'd1;
            if (w_tick) begin
                r_framectr <= w_boundary ? 10'd0 : r_framectr + 10'd1;
            end
        end
    end

    // A boundary sees the buffer state from before this cycle's accept, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // NOTE: buffer data has no reset; r_buf_full alone says whether it holds a sample.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active   <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_starve;
            if ((r_state == RAMP) && w_tick) begin
                r_active <= w_ramp_next;
            end else if (w_load) begin
                r_active <= r_buf;
            end
        end
    end

    dsdac_mod #(
        .WIDTH (WIDTH)
    ) u_mod (
        .clk     (clk),
        .rst     (rst),
        .i_tick  (w_tick),
        .i_level (r_active),
        .o_pdm   (pdmout)
    );

    assign sample_ready = (r_state != IDLE) && !r_buf_full;
    assign underrun     = r_underrun;
    assign running      = (r_state == RUN);

endmodule

// File: tb/tb_dsdac.sv
// Self-checking bench for dsdac: per-cycle comparison against an arithmetic model plus directed scenarios.
module tb_dsdac;

    localparam int FULL = 65536;
    localparam int HALF = 32768;
    localparam int STEP = 16;

    logic        clk;
    logic        rst;
    logic [4:0]  divider;
    logic [9:0]  osr;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        pdmout;
    logic        underrun;
    logic        running;

    dsdac #(
        .WIDTH     (16),
        .RAMP_STEP (STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .divider      (divider),
        .osr          (osr),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pdmout       (pdmout),
        .underrun     (underrun),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Model: phase 0 idle, 1 ramping, 2 running; integers hold counters, levels and buffer.
    int m_div, m_frame, m_acc, m_active, m_buf, m_phase, n_edges;
    bit m_full, m_pdm, m_und;
    bit mt_tick, mt_bnd, mt_accept;
    int mt_sum, mt_old_active;

    always @(posedge clk) begin
        if (rst) begin
            m_div = 0; m_frame = 0; m_acc = 0; m_active = 0; m_buf = 0;
            m_phase = 0; n_edges = 0; m_full = 0; m_pdm = 0; m_und = 0;
        end else begin
            n_edges++;
            mt_tick       = (m_div >= int'(divider));
            mt_bnd        = mt_tick && (m_frame == int'(osr));
            mt_accept     = sample_valid && (m_phase != 0) && !m_full;
            mt_old_active = m_active;
            m_und         = 0;
            if (mt_tick) begin
                mt_sum = m_acc + m_active;
                m_pdm  = (mt_sum >= FULL);
                m_acc  = mt_sum % FULL;
                m_frame = mt_bnd ? 0 : m_frame + 1;
            end
            m_div = mt_tick ? 0 : m_div + 1;
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    if (mt_tick) m_active = (m_active + STEP > HALF) ? HALF : m_active + STEP;
                    if (mt_old_active >= HALF) m_phase = 2;
                end
                default: begin
                    if (mt_bnd) begin
                        if (m_full) begin
                            m_active = m_buf;
                            m_full   = 0;
                        end else begin
                            m_und = 1;
                        end
                    end
                end
            endcase
            if (mt_accept) begin
                m_buf  = int'(sample_in);
                m_full = 1;
            end
        end
    end

    // Compare and monitor, 1 time unit after each rising edge.
    int ones_cnt = 0;
    int und_cnt  = 0;
    int bad_cnt  = 0;
    logic last_pdm = 1'b0;

    always @(posedge clk) begin
        #1;
        check("pdmout", pdmout, m_pdm);
        check("sample_ready", sample_ready, (m_phase != 0) && !m_full);
        check("underrun", underrun, m_und);
        check("running", running, m_phase == 2);
        ones_cnt += int'(pdmout);
        und_cnt  += int'(underrun);
        if (!rst && (pdmout !== last_pdm) && ((n_edges % (int'(divider) + 1)) != 0)) bad_cnt++;
        last_pdm = pdmout;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        for (int i = 0; i < 20000 && n_edges < n; i++) @(negedge clk);
        check("edge_reached", n_edges, n);
    endtask

    task automatic wait_running(input string name, input int exp_edges);
        for (int i = 0; i < 20000 && !running; i++) @(negedge clk);
        check(name, n_edges, exp_edges);
    endtask

    task automatic send(input logic [15:0] v);
        int done;
        done = 0;
        sample_in    = v;
        sample_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (sample_ready) begin
                done = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check("send_accepted", done, 1);
    endtask

    int o0, u0, b0;

    initial begin
        rst = 1'b1; divider = 5'd0; osr = 10'd1023; sample_in = 16'h8000; sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pdmout", pdmout, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_running", running, 0);

        // Mid-scale, then zero, then full scale, with divider 0 and 1024-tick frames.
        do_reset();
        wait_running("ramp_len_div0", 2050);
        o0 = ones_cnt; wait_edges(1024);
        check_range("density_8000", ones_cnt - o0, 511, 513);
        sample_in = 16'h0000; wait_edges(2100);
        o0 = ones_cnt; wait_edges(1024);
        check("density_0000", ones_cnt - o0, 0);
        sample_in = 16'hFFFF; wait_edges(2100);
        o0 = ones_cnt; wait_edges(4096);
        check_range("density_ffff", ones_cnt - o0, 4095, 4096);

        // divider=3: output only moves after ticks; ramp is 2048 ticks.
        rst = 1'b1; divider = 5'd3; osr = 10'd7; sample_in = 16'h4000;
        do_reset();
        b0 = bad_cnt;
        wait_running("ramp_len_div3", 8193);
        wait_until(8256);
        o0 = ones_cnt;
        wait_until(8656);
        check_range("density_4000_div3", ones_cnt - o0, 96, 104);
        check("pdm_change_off_tick", bad_cnt - b0, 0);

        // Producer stops after two samples; 16-tick frames.
        rst = 1'b1; divider = 5'd0; osr = 10'd15; sample_valid = 1'b0;
        do_reset();
        u0 = und_cnt;
        send(16'h1000);
        send(16'hC000);
        sample_valid = 1'b0;
        check("second_accept_edge", n_edges, 2065);
        check("underrun_in_ramp", und_cnt - u0, 0);
        wait_until(2112);
        o0 = ones_cnt;
        wait_until(2368);
        check_range("hold_last_sample", ones_cnt - o0, 191, 193);
        check("underrun_pulses", und_cnt - u0, 18);

        // Sample offered in the exact cycle of an empty boundary.
        wait_until(2383);
        sample_in = 16'h2000; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("same_cycle_underrun", underrun, 1);
        check("same_cycle_buffered", sample_ready, 0);
        wait_until(2400);
        check("next_boundary_no_underrun", underrun, 0);
        check("next_boundary_loaded", sample_ready, 1);
        wait_until(2416);
        o0 = ones_cnt;
        wait_until(2672);
        check_range("density_2000", ones_cnt - o0, 31, 33);

        // Reset mid-frame with the buffer full.
        wait_until(2677);
        sample_in = 16'h7777; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("buffer_full_before_rst", sample_ready, 0);
        wait_until(2680);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pdmout", pdmout, 0);
        check("midrst_ready", sample_ready, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_running", running, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("buffer_discarded", sample_ready, 1);
        wait_running("ramp_len_after_rst", 2050);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
